// File: rtl/mxv_row_stream_ctrl.sv
// Streams a num_rows x total matrix against a vector, NO_OF_UNITS lanes per beat,
// producing one signed dot product per row with a result handshake and one AP-memory write per row.
module mxv_row_stream_ctrl #(
   parameter int ELEMENT_WIDTH = 32,
   parameter int NO_OF_UNITS   = 8,
   parameter int ACC_WIDTH     = 72,
   parameter int ROW_WIDTH     = 16
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [31:0]                           total,
   input  logic [ROW_WIDTH-1:0]                  num_rows,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  row_chunk,
   input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0]  vec_chunk,
   output logic [ACC_WIDTH-1:0]                  result,
   output logic                                  result_valid,
   input  logic                                  result_ready,
   output logic                                  ap_mem_we,
   output logic [ROW_WIDTH-1:0]                  ap_mem_addr,
   output logic [31:0]                           counter2,
   output logic                                  busy,
   output logic                                  finish,
   output logic                                  error
);

   localparam int LANE_BITS  = $clog2(NO_OF_UNITS);
   localparam int PROD_WIDTH = 2 * ELEMENT_WIDTH;
   localparam int SUM_WIDTH  = PROD_WIDTH + LANE_BITS;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_STREAM = 3'd1;
   localparam logic [2:0] S_DRAIN  = 3'd2;
   localparam logic [2:0] S_OUTPUT = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]                     state;
   logic [31:0]                    chunks_per_row;
   logic [LANE_BITS:0]             tail_lanes;
   logic [ROW_WIDTH-1:0]           rows_q;
   logic [ROW_WIDTH-1:0]           row;
   logic [ACC_WIDTH-1:0]           acc;
   logic signed [PROD_WIDTH-1:0]   prod [NO_OF_UNITS];
   logic signed [PROD_WIDTH-1:0]   prod_next [NO_OF_UNITS];
   logic signed [SUM_WIDTH-1:0]    tree [2*NO_OF_UNITS];
   logic signed [SUM_WIDTH-1:0]    sum_q;
   logic                           s1_valid;
   logic                           s2_valid;
   logic                           s3_valid;
   logic [NO_OF_UNITS-1:0]         lane_on;
   logic                           accept;
   logic                           last_chunk;
   logic                           row_handshake;
   logic                           pipe_empty;
   logic [31:0]                    start_chunks;
   logic [LANE_BITS:0]             start_tail;

   assign in_ready      = (state == S_STREAM);
   assign busy          = (state != S_IDLE);
   assign accept        = in_valid & in_ready;
   assign last_chunk    = (counter2 == chunks_per_row - 32'd1);
   assign row_handshake = (state == S_OUTPUT) & result_valid & result_ready;
   assign pipe_empty    = ~(s1_valid | s2_valid | s3_valid);
   assign ap_mem_we     = row_handshake;
   assign ap_mem_addr   = row;

   // ceil(total/NO_OF_UNITS) and the count of live lanes in the final beat (full beat when total is a multiple)
   assign start_chunks = (total >> LANE_BITS) + {31'd0, |total[LANE_BITS-1:0]};
   assign start_tail   = (total[LANE_BITS-1:0] == '0) ? (LANE_BITS+1)'(NO_OF_UNITS)
                                                      : {1'b0, total[LANE_BITS-1:0]};

   always_comb begin
      lane_on = '0;
      for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
         lane_on[i] = !last_chunk || ((LANE_BITS+1)'(i) < tail_lanes);
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
         prod_next[i] = '0;
         if (lane_on[i]) begin
            prod_next[i] = PROD_WIDTH'($signed(row_chunk[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]))
                         * PROD_WIDTH'($signed(vec_chunk[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]));
         end
      end
   end

   // Heap-indexed binary tree: leaves at [N..2N-1], node k sums 2k and 2k+1, root at [1]
   always_comb begin
      tree = '{default: '0};
      for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
         tree[NO_OF_UNITS + i] = SUM_WIDTH'(prod[i]);
      end
      for (int unsigned k = NO_OF_UNITS - 1; k >= 1; k--) begin
         tree[k] = tree[2*k] + tree[2*k + 1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         chunks_per_row <= '0;
         tail_lanes     <= '0;
         rows_q         <= '0;
         row            <= '0;
         acc            <= '0;
         sum_q          <= '0;
         s1_valid       <= 1'b0;
         s2_valid       <= 1'b0;
         s3_valid       <= 1'b0;
         result         <= '0;
         result_valid   <= 1'b0;
         counter2       <= '0;
         finish         <= 1'b0;
         error          <= 1'b0;
         for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
            prod[i] <= '0;
         end
      end else begin
         finish   <= 1'b0;
         error    <= 1'b0;
         s1_valid <= accept;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;

         if (accept) begin
            for (int unsigned i = 0; i < NO_OF_UNITS; i++) begin
               prod[i] <= prod_next[i];
            end
         end
         if (s1_valid) begin
            sum_q <= tree[1];
         end
         if (s2_valid) begin
            acc <= acc + ACC_WIDTH'(sum_q);
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  if (total == '0 || num_rows == '0) begin
                     error  <= 1'b1;
                     finish <= 1'b1;
                  end else begin
                     chunks_per_row <= start_chunks;
                     tail_lanes     <= start_tail;
                     rows_q         <= num_rows;
                     row            <= '0;
                     acc            <= '0;
                     counter2       <= '0;
                     state          <= S_STREAM;
                  end
               end
            end
            S_STREAM: begin
               if (accept) begin
                  counter2 <= counter2 + 32'd1;
                  if (last_chunk) begin
                     state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (pipe_empty) begin
                  result       <= acc;
                  result_valid <= 1'b1;
                  state        <= S_OUTPUT;
               end
            end
            S_OUTPUT: begin
               if (row_handshake) begin
                  result_valid <= 1'b0;
                  counter2     <= '0;
                  acc          <= '0;
                  row          <= row + ROW_WIDTH'(1);
                  state        <= (row == rows_q - ROW_WIDTH'(1)) ? S_DONE : S_STREAM;
               end
            end
            S_DONE: begin
               finish <= 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mxv_row_stream_ctrl.sv
// Scoreboard bench for mxv_row_stream_ctrl: the driver pushes per-row dot products computed
// from element arrays, and a negedge monitor pops and compares them on each result handshake.
module tb_mxv_row_stream_ctrl;

   localparam int EW = 32;
   localparam int N  = 8;
   localparam int AW = 72;
   localparam int RW = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic [31:0]     total = '0;
   logic [RW-1:0]   num_rows = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [EW*N-1:0] row_chunk = '0;
   logic [EW*N-1:0] vec_chunk = '0;
   logic [AW-1:0]   result;
   logic            result_valid;
   logic            result_ready = 1'b0;
   logic            ap_mem_we;
   logic [RW-1:0]   ap_mem_addr;
   logic [31:0]     counter2;
   logic            busy;
   logic            finish;
   logic            error;

   int checks = 0;
   int failures = 0;
   int rr_policy = 0;

   typedef struct {
      logic [AW-1:0] value;
      logic [RW-1:0] addr;
      logic [31:0]   chunks;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic [AW-1:0] prev_result = '0;
   bit prev_hold = 1'b0;

   mxv_row_stream_ctrl #(
      .ELEMENT_WIDTH(EW),
      .NO_OF_UNITS(N),
      .ACC_WIDTH(AW),
      .ROW_WIDTH(RW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .total(total),
      .num_rows(num_rows),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .row_chunk(row_chunk),
      .vec_chunk(vec_chunk),
      .result(result),
      .result_valid(result_valid),
      .result_ready(result_ready),
      .ap_mem_we(ap_mem_we),
      .ap_mem_addr(ap_mem_addr),
      .counter2(counter2),
      .busy(busy),
      .finish(finish),
      .error(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Consumer-side readiness: 0 always ready, 1 random, 2 held low
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rr_policy)
            0:       result_ready = 1'b1;
            1:       result_ready = 1'($urandom_range(0, 1));
            default: result_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", result_valid, 1);
            check("hold_result", result, prev_result);
         end
         if (result_valid && result_ready) begin
            check("we_on_handshake", ap_mem_we, 1);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write addr=%0d result=%0h required=none", ap_mem_addr, result);
            end else begin
               mon_e = sb.pop_front();
               check("result", result, mon_e.value);
               check("addr", ap_mem_addr, mon_e.addr);
               check("counter2", counter2, mon_e.chunks);
            end
         end else if (ap_mem_we) begin
            check("stray_we", ap_mem_we, 0);
         end
         prev_hold   = result_valid && !result_ready;
         prev_result = result;
      end
   end

   task automatic do_start(input logic [31:0] t, input logic [RW-1:0] r);
      start    = 1'b1;
      total    = t;
      num_rows = r;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [EW*N-1:0] rc, input logic [EW*N-1:0] vc,
                            input int gmin, input int gmax);
      bit taken;
      int guard;
      repeat ($urandom_range(gmin, gmax)) begin
         in_valid  = 1'b0;
         row_chunk = {N{$urandom}};
         vec_chunk = {N{$urandom}};
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b1;
      row_chunk = rc;
      vec_chunk = vc;
      taken = 1'b0;
      guard = 0;
      while (!taken && guard < 300) begin
         @(negedge clk);
         taken = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      in_valid  = 1'b0;
      row_chunk = {N{$urandom}};
      if (!taken) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout actual=no_accept required=accept");
      end
   endtask

   task automatic fill_elems(input int t, input int rows, input int pattern,
                             output logic signed [EW-1:0] me [4][64],
                             output logic signed [EW-1:0] ve [64]);
      for (int k = 0; k < 64; k++) begin
         ve[k] = $urandom;
         for (int r = 0; r < 4; r++) me[r][k] = $urandom;
         if (k < t) begin
            case (pattern)
               1: begin ve[k] = 2; for (int r = 0; r < 4; r++) me[r][k] = k + 1; end
               2: begin ve[k] = 3; for (int r = 0; r < 4; r++) me[r][k] = 1; end
               3: begin ve[k] = 7; for (int r = 0; r < 4; r++) me[r][k] = -5; end
               default: ;
            endcase
         end else if (pattern == 2) begin
            ve[k] = 1000;
            for (int r = 0; r < 4; r++) me[r][k] = 1000;
         end
      end
   endtask

   function automatic logic [AW-1:0] dot(input int t, input int r,
                                         input logic signed [EW-1:0] me [4][64],
                                         input logic signed [EW-1:0] ve [64]);
      logic signed [AW-1:0] s, a, b;
      s = '0;
      for (int k = 0; k < t; k++) begin
         a = me[r][k];
         b = ve[k];
         s = s + a * b;
      end
      return s;
   endfunction

   task automatic send_row(input int t, input int r, input int gmin, input int gmax, input bit poke,
                           input logic signed [EW-1:0] me [4][64],
                           input logic signed [EW-1:0] ve [64]);
      logic [EW*N-1:0] rc, vc;
      int cpr;
      cpr = (t + N - 1) / N;
      sb.push_back('{dot(t, r, me, ve), RW'(r), 32'(cpr)});
      for (int b = 0; b < cpr; b++) begin
         for (int l = 0; l < N; l++) begin
            rc[l*EW +: EW] = me[r][b*N + l];
            vc[l*EW +: EW] = ve[b*N + l];
         end
         send_beat(rc, vc, gmin, gmax);
         if (poke && b == 0 && cpr > 1) begin
            do_start(0, 0);
            @(negedge clk);
            check("busy_start_no_error", error, 0);
            check("busy_start_busy", busy, 1);
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic run_job(input int t, input int rows, input int pattern, input int gmin,
                          input int gmax, input bit hold_low, input bit poke);
      logic signed [EW-1:0] me [4][64];
      logic signed [EW-1:0] ve [64];
      bit seen;
      fill_elems(t, rows, pattern, me, ve);
      do_start(t, rows);
      for (int r = 0; r < rows; r++) begin
         send_row(t, r, gmin, gmax, poke && r == 0, me, ve);
         for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) check("in_ready_drop", in_ready, 0);
            if (c < 5) check("early_valid", result_valid, 0);
            else       check("latency_valid", result_valid, 1);
         end
         if (hold_low && r == 0) begin
            repeat (10) begin
               @(negedge clk);
               check("bp_in_ready", in_ready, 0);
               check("bp_no_we", ap_mem_we, 0);
               check("bp_valid", result_valid, 1);
            end
            rr_policy = 1;
         end
         @(posedge clk);
         #1;
      end
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge clk);
         if (finish) seen = 1'b1;
      end
      check("finish_seen", seen, 1);
      if (seen) check("idle_at_finish", busy, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic illegal_start(input logic [31:0] t, input logic [RW-1:0] r);
      do_start(t, r);
      @(negedge clk);
      check("illegal_error", error, 1);
      check("illegal_finish", finish, 1);
      check("illegal_busy", busy, 0);
      @(negedge clk);
      check("illegal_error_pulse", error, 0);
      check("illegal_finish_pulse", finish, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_mid_job();
      logic signed [EW-1:0] me [4][64];
      logic signed [EW-1:0] ve [64];
      logic [EW*N-1:0] rc, vc;
      int guard;
      rr_policy = 0;
      fill_elems(16, 3, 0, me, ve);
      do_start(16, 3);
      send_row(16, 0, 0, 1, 1'b0, me, ve);
      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("row0_written", sb.size(), 0);
      @(posedge clk);
      #1;
      for (int l = 0; l < N; l++) begin
         rc[l*EW +: EW] = me[1][l];
         vc[l*EW +: EW] = ve[l];
      end
      send_beat(rc, vc, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_outputs",
            {in_ready, result, result_valid, ap_mem_we, ap_mem_addr, counter2, busy, finish, error}, '0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      run_job(8, 1, 1, 0, 0, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      #3;
      check("reset_state",
            {in_ready, result, result_valid, ap_mem_we, ap_mem_addr, counter2, busy, finish, error}, '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      rr_policy = 0;
      run_job(8, 1, 1, 0, 0, 1'b0, 1'b0);
      rr_policy = 1;
      run_job(13, 2, 2, 0, 2, 1'b0, 1'b0);
      rr_policy = 2;
      run_job(20, 2, 0, 0, 1, 1'b1, 1'b1);
      illegal_start(0, 3);
      illegal_start(16, 0);
      rr_policy = 0;
      run_job(16, 1, 3, 1, 1, 1'b0, 1'b0);
      for (int j = 0; j < 12; j++) begin
         rr_policy = 1;
         run_job($urandom_range(1, 40), $urandom_range(1, 4), 0, 0, 2, 1'b0, (j % 3) == 0);
      end
      reset_mid_job();

      check("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
